// File: rtl/data_ram_lsu.sv
// Load/store unit in front of a byte-lane data RAM: byte/halfword/word accesses,
// little-endian, with optional hardware split of word-crossing accesses.
module data_ram_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 12,
    parameter int MISALIGN_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int WIDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [WIDX_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              req_bad;
    logic [1:0]        offset;
    logic [WIDX_W-1:0] widx, widx_nxt;
    logic [2:0]        nbytes;
    logic [3:0]        lane_mask;
    logic              crossing;
    logic [7:0]        be_wide;
    logic [63:0]       wdata_wide;

    logic              mem_en;
    logic              mem_we;
    logic [WIDX_W-1:0] mem_idx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    logic [3:0][7:0]   mem [DEPTH_WORDS];
    logic [31:0]       rd_lo_q;
    logic [23:0]       rd_hi_q;
    logic [31:0]       rd_shift;
    logic [31:0]       load_ext;

    // Address bits above the word index only alias the same RAM.
    if (ADDR_W > WIDX_W + 2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[ADDR_W-1:WIDX_W+2];
    end

    assign req_bad = (req_size == 2'b11) ||
                     ((MISALIGN_EN == 0) &&
                      ((req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00)));

    assign offset   = addr_q[1:0];
    assign widx     = addr_q[WIDX_W+1:2];
    assign widx_nxt = widx + 1'b1;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        nbytes    = 3'd4;
        lane_mask = 4'b1111;
        case (size_q)
            2'b00: begin nbytes = 3'd1; lane_mask = 4'b0001; end
            2'b01: begin nbytes = 3'd2; lane_mask = 4'b0011; end
            default: ;
        endcase
    end

    assign crossing   = ({1'b0, offset} + nbytes) > 3'd4;
    assign be_wide    = {4'b0000, lane_mask} << offset;
    assign wdata_wide = {32'h0, wdata_q} << {offset, 3'b000};

    // ACC1 touches word W (low half of the 64-bit lane view), ACC2 touches W+1.
    assign mem_en    = ((state_q == S_ACC1) || (state_q == S_ACC2)) && !err_q;
    assign mem_we    = mem_en && we_q;
    assign mem_idx   = (state_q == S_ACC2) ? widx_nxt : widx;
    assign mem_be    = (state_q == S_ACC2) ? be_wide[7:4] : be_wide[3:0];
    assign mem_wdata = (state_q == S_ACC2) ? wdata_wide[63:32] : wdata_wide[31:0];

    // NOTE: the RAM array and its read registers are never reset; only control state is.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_we && mem_be[k]) begin
                    mem[mem_idx][k] <= mem_wdata[8*k +: 8];
                end
            end
            if (state_q == S_ACC2) begin
                rd_hi_q <= mem[mem_idx][2:0];
            end else begin
                rd_lo_q <= mem[mem_idx];
            end
        end
    end

    always_comb begin
        rd_shift = rd_lo_q;
        case (offset)
            2'd1: rd_shift = {rd_hi_q[7:0],  rd_lo_q[31:8]};
            2'd2: rd_shift = {rd_hi_q[15:0], rd_lo_q[31:16]};
            2'd3: rd_shift = {rd_hi_q[23:0], rd_lo_q[31:24]};
            default: ;
        endcase
    end

    always_comb begin
        load_ext = rd_shift;
        case (size_q)
            2'b00: load_ext = uns_q ? {24'h0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01: load_ext = uns_q ? {16'h0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[WIDX_W+1:0];
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    state_d = S_ACC1;
                end
            end
            S_ACC1:  state_d = (!err_q && crossing) ? S_ACC2 : S_RESP;
            S_ACC2:  state_d = S_RESP;
            default: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = (state_q == S_RESP && !err_q && !we_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_data_ram_lsu.sv
// Directed bench for data_ram_lsu: one instance with misaligned support, one without.
module tb_data_ram_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        req_ready_a, req_ready_b;
    logic        resp_valid_a, resp_valid_b;
    logic [31:0] resp_rdata_a, resp_rdata_b;
    logic        resp_err_a, resp_err_b;

    int vectors;
    int miscompares;

    data_ram_lsu #(.DEPTH_WORDS(1024), .ADDR_W(12), .MISALIGN_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    data_ram_lsu #(.DEPTH_WORDS(1024), .ADDR_W(12), .MISALIGN_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request, measure edges from accept (accept edge = 1) to resp_valid, retire it.
    task automatic do_req(input bit sel_b, input logic we, input logic [1:0] size,
                          input logic uns, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        logic seen;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (sel_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            seen = sel_b ? resp_valid_b : resp_valid_a;
        end
        rdata = sel_b ? resp_rdata_b : resp_rdata_a;
        err   = sel_b ? resp_err_b : resp_err_a;
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL resp_timeout: addr=%h no resp_valid within %0d edges", addr, lat);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (resp_valid_a !== 1'b0 || resp_err_a !== 1'b0 || resp_rdata_a !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b err=%b rdata=%h, expected 0/0/00000000",
                     resp_valid_a, resp_err_a, resp_rdata_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready_a !== 1'b1 || req_ready_b !== 1'b1 || resp_valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: ready_a=%b ready_b=%b valid_b=%b, expected 1/1/0",
                     req_ready_a, req_ready_b, resp_valid_b);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        do_req(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, rd, er, lat);
        vectors++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL sw_010: lat=%0d err=%b rdata=%h, expected 2/0/00000000", lat, er, rd);
        end
        do_req(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, rd, er, lat);
        vectors++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lw_010: lat=%0d err=%b rdata=%h, expected 2/0/deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_subword;
        logic [1:0]  t_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        t_uns  [5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        logic [11:0] t_addr [5] = '{12'h013, 12'h013, 12'h012, 12'h010, 12'h010};
        logic [31:0] t_exp  [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                                    32'h0000BEEF, 32'hFFFFFFEF};
        logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 5; i++) begin
            do_req(0, 1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, rd, er, lat);
            vectors++;
            if (lat !== 2 || er !== 1'b0 || rd !== t_exp[i]) begin
                miscompares++;
                $display("FAIL subword_load[%0d] addr=%h: lat=%0d err=%b rdata=%h, expected 2/0/%h",
                         i, t_addr[i], lat, er, rd, t_exp[i]);
            end
        end
        // Byte store must leave the other three lanes alone.
        do_req(0, 1'b1, 2'b00, 1'b0, 12'h011, 32'hFFFFFF77, rd, er, lat);
        do_req(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hDEAD77EF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_lane: rdata=%h err=%b, expected dead77ef/0", rd, er);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic er; int lat;
        do_req(0, 1'b1, 2'b11, 1'b0, 12'h010, 32'h00000000, rd, er, lat);
        vectors++;
        if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL illegal_size: lat=%0d err=%b rdata=%h, expected 2/1/00000000", lat, er, rd);
        end
        do_req(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hDEAD77EF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_nowrite: rdata=%h err=%b, expected dead77ef/0", rd, er);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic er; int lat;
        logic [1:0]  t_size [4] = '{2'b00, 2'b00, 2'b10, 2'b10};
        logic [11:0] t_addr [4] = '{12'h020, 12'h025, 12'h020, 12'h024};
        logic [31:0] t_exp  [4] = '{32'h0000000D, 32'h00000045, 32'h2233440D, 32'h01234511};
        do_req(0, 1'b1, 2'b10, 1'b0, 12'h020, 32'hCAFEF00D, rd, er, lat);
        do_req(0, 1'b1, 2'b10, 1'b0, 12'h024, 32'h01234567, rd, er, lat);
        do_req(0, 1'b1, 2'b10, 1'b0, 12'h021, 32'h11223344, rd, er, lat);
        vectors++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL sw_021: lat=%0d err=%b rdata=%h, expected 3/0/00000000", lat, er, rd);
        end
        do_req(0, 1'b0, 2'b10, 1'b0, 12'h021, 32'h0, rd, er, lat);
        vectors++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h11223344) begin
            miscompares++;
            $display("FAIL lw_021: lat=%0d err=%b rdata=%h, expected 3/0/11223344", lat, er, rd);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b0, t_size[i], 1'b1, t_addr[i], 32'h0, rd, er, lat);
            vectors++;
            if (rd !== t_exp[i] || er !== 1'b0) begin
                miscompares++;
                $display("FAIL misaligned_neighbour[%0d] addr=%h: rdata=%h err=%b, expected %h/0",
                         i, t_addr[i], rd, er, t_exp[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic er; int lat;
        logic [1:0]  t_size [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        t_uns  [4] = '{1'b1,  1'b1,  1'b1,  1'b0};
        logic [11:0] t_addr [4] = '{12'hFFF, 12'h000, 12'hFFF, 12'hFFF};
        logic [31:0] t_exp  [4] = '{32'h000000B6, 32'h000000A5, 32'h0000A5B6, 32'hFFFFA5B6};
        int          t_lat  [4] = '{2, 2, 3, 3};
        do_req(0, 1'b1, 2'b01, 1'b0, 12'hFFF, 32'h0000A5B6, rd, er, lat);
        vectors++;
        if (lat !== 3 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sh_fff: lat=%0d err=%b, expected 3/0", lat, er);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, rd, er, lat);
            vectors++;
            if (lat !== t_lat[i] || rd !== t_exp[i] || er !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_load[%0d] addr=%h: lat=%0d rdata=%h err=%b, expected %0d/%h/0",
                         i, t_addr[i], lat, rd, er, t_lat[i], t_exp[i]);
            end
        end
    endtask

    task automatic test_no_misalign;
        logic [31:0] rd; logic er; int lat;
        do_req(1, 1'b1, 2'b10, 1'b0, 12'h000, 32'h5A5A1234, rd, er, lat);
        do_req(1, 1'b0, 2'b10, 1'b0, 12'h002, 32'h0, rd, er, lat);
        vectors++;
        if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL strict_lw_002: lat=%0d err=%b rdata=%h, expected 2/1/00000000", lat, er, rd);
        end
        do_req(1, 1'b1, 2'b01, 1'b0, 12'h001, 32'h0000FFFF, rd, er, lat);
        vectors++;
        if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL strict_sh_001: lat=%0d err=%b rdata=%h, expected 2/1/00000000", lat, er, rd);
        end
        do_req(1, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h5A5A1234 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL strict_lw_000: rdata=%h err=%b, expected 5a5a1234/0", rd, er);
        end
        do_req(1, 1'b0, 2'b01, 1'b0, 12'h002, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h00005A5A || er !== 1'b0) begin
            miscompares++;
            $display("FAIL strict_lh_002: rdata=%h err=%b, expected 00005a5a/0", rd, er);
        end
        do_req(1, 1'b0, 2'b00, 1'b0, 12'h003, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h0000005A || er !== 1'b0) begin
            miscompares++;
            $display("FAIL strict_lb_003: rdata=%h err=%b, expected 0000005a/0", rd, er);
        end
    endtask

    task automatic test_stall;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 12'h010; req_wdata = 32'h0;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if (resp_valid_a !== 1'b1 || resp_rdata_a !== 32'hDEAD77EF ||
                resp_err_a !== 1'b0 || req_ready_a !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b rdata=%h err=%b ready=%b, expected 1/dead77ef/0/0",
                         c, resp_valid_a, resp_rdata_a, resp_err_a, req_ready_a);
            end
            if (c < 5) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        vectors++;
        if (resp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_retire: valid=%b ready=%b, expected 0/1", resp_valid_a, req_ready_a);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic er; int lat;
        do_req(0, 1'b1, 2'b10, 1'b0, 12'h030, 32'h00000000, rd, er, lat);
        do_req(0, 1'b1, 2'b10, 1'b0, 12'h034, 32'h00000000, rd, er, lat);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 12'h032; req_wdata = 32'hAABBCCDD;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        vectors++;
        if (req_ready_a !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ready: ready=%b, expected 0", req_ready_a);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (resp_valid_a !== 1'b0 || resp_err_a !== 1'b0 || resp_rdata_a !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: valid=%b err=%b rdata=%h, expected 0/0/00000000",
                     resp_valid_a, resp_err_a, resp_rdata_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_ready: ready=%b, expected 1", req_ready_a);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (resp_valid_a !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_resp[%0d]: valid=%b, expected 0", c, resp_valid_a);
            end
        end
        do_req(0, 1'b0, 2'b10, 1'b0, 12'h030, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hCCDD0000 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_word_w: rdata=%h err=%b, expected ccdd0000/0", rd, er);
        end
        do_req(0, 1'b0, 2'b10, 1'b0, 12'h034, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h00000000 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_word_w1: rdata=%h err=%b, expected 00000000/0", rd, er);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        req_valid_a  = 1'b0;
        req_valid_b  = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 12'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;

        test_reset();
        test_word();
        test_subword();
        test_illegal();
        test_stall();
        test_misaligned();
        test_wrap();
        test_no_misalign();
        test_reset_abort();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
